win_line_buf: RTL

Parametrised sliding-window line buffer for the camera pixel path. It turns a raster pixel stream (pdata/pvld with hsync/vsync) into WIN x WIN pixel windows on an AXI-stream master. It generalises the fixed 3-line, 3x3 buffer in window size, pixel width and line length. It adds frame alignment, an output FIFO, and sticky overflow and line-length error reporting. It sits between the pixel capture front end and the colour-band classifier.

---
 rtl/win_line_buf_pkg.sv | 21 ++
 rtl/win_line_buf_fifo.sv | 65 ++++++
 rtl/win_line_buf_ram.sv | 25 ++
 rtl/win_line_buf.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/win_line_buf_pkg.sv
// Shared constants and types for the sliding-window line buffer.
// Holds only constants and types; nothing here is parametrised.
package win_line_buf_pkg;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned WIN_MAX    = 7;
  localparam int unsigned CH_W       = 8;

  // Default pixel layout: {red, grn, blu}.
  typedef struct packed {
    logic [CH_W-1:0] red;
    logic [CH_W-1:0] grn;
    logic [CH_W-1:0] blu;
  } pixel_t;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_t;

endpackage

// File: rtl/win_line_buf_fifo.sv
// Synchronous output FIFO with vld/rdy read side; writes into a full FIFO
// are dropped (the producer has no backpressure).
// Ports: clk, rst_n; wr_en/wr_data push side; full status;
//        vld/rdy/rd_data pop side (rd_data stable while vld & ~rdy).
module win_line_buf_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          vld,
  input  logic          rdy,
  output logic [DW-1:0] rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic          push;
  logic          pop;

  assign push    = wr_en & ~full;
  assign pop     = vld & rdy;
  assign rd_data = mem[rd_ptr];

  // Occupancy next value.
  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + (AW+1)'(1);
      2'b01:   cnt_nxt = cnt - (AW+1)'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Pointers, count and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
      full   <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      vld  <= (cnt_nxt != '0);
      full <= (cnt_nxt == (AW+1)'(DEPTH));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/win_line_buf_ram.sv
// Simple dual-port line RAM, 1-cycle registered read, read-before-write.
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata read data.
module win_line_buf_ram #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Non-blocking semantics give the old word when raddr == waddr.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/win_line_buf.sv
// Sliding-window line buffer: raster pixels (pdata/pvld, hsync/vsync) in,
// WIN x WIN windows out on a vld/rdy stream. data[r][c], r=0 oldest row
// (top), c=0 oldest column (left).
// Ports: clk, rst_n; en; pdata/pvld; hsync/vsync;
//        axis_o_data/axis_o_vld/axis_o_rdy window stream;
//        ovf_clr; ovf, len_err sticky flags; frame_done pulse.
module win_line_buf
  import win_line_buf_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned WIN        = 3,
  parameter int unsigned MAX_COLS   = 1024,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic [DATA_W-1:0]                      pdata,
  input  logic                                   pvld,
  input  logic                                   hsync,
  input  logic                                   vsync,
  output logic [WIN-1:0][WIN-1:0][DATA_W-1:0]    axis_o_data,
  output logic                                   axis_o_vld,
  input  logic                                   axis_o_rdy,
  input  logic                                   ovf_clr,
  output logic                                   ovf,
  output logic                                   len_err,
  output logic                                   frame_done
);

  localparam int unsigned NR    = WIN - 1;
  localparam int unsigned AW    = $clog2(MAX_COLS);
  localparam int unsigned COL_W = AW + 1;
  localparam int unsigned ROW_W = $clog2(WIN);
  localparam int unsigned IDX_W = $clog2(NR);
  localparam int unsigned WIN_BITS = WIN * WIN * DATA_W;

  typedef logic [WIN-1:0][WIN-1:0][DATA_W-1:0] win_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          hs_q;
  logic [1:0]          vs_q;
  logic                fm_end;
  logic                ln_end;
  logic                line_clr;
  logic                counted;
  logic [COL_W-1:0]    col;
  logic [COL_W-1:0]    col_eff;
  logic [ROW_W-1:0]    row;
  logic [ROW_W-1:0]    row_eff;
  logic [NR-1:0]       ptr;
  logic [NR-1:0]       ptr_eff;
  logic [IDX_W-1:0]    old_idx;
  logic [IDX_W-1:0]    old_idx_d;
  logic                px_in;
  logic                acc;
  logic                acc_d;
  logic                emit_d;
  logic                emit_q;
  logic [DATA_W-1:0]   pix_d;
  logic [DATA_W-1:0]   rd_data [NR];
  logic [WIN-1:0][DATA_W-1:0] colvec;
  win_t                win;
  logic                fifo_full;

  // Falling-edge detect on the sync shift registers; fm_end masks ln_end.
  assign fm_end   = vs_q[1] & ~vs_q[0];
  assign ln_end   = hs_q[1] & ~hs_q[0] & ~fm_end;
  assign line_clr = ln_end | fm_end;
  assign counted  = ln_end & (col != '0);

  // Counters and ring pointer as seen by a pixel arriving this cycle, so a
  // same-cycle line end is applied before the pixel is stored.
  always_comb begin
    col_eff = line_clr ? '0 : col;
    row_eff = row;
    ptr_eff = ptr;
    if (fm_end) begin
      row_eff = '0;
    end else if (counted) begin
      ptr_eff = {ptr[NR-2:0], ptr[NR-1]};
      if (row != ROW_W'(WIN - 1)) row_eff = row + ROW_W'(1);
    end
  end

  assign px_in = pvld & en & (state == RUN);
  assign acc   = px_in & (col_eff < COL_W'(MAX_COLS));

  // One-hot oldest-line pointer to index.
  always_comb begin
    old_idx = '0;
    for (int k = 0; k < int'(NR); k++) begin
      if (ptr_eff[k]) old_idx = IDX_W'(k);
    end
  end

  // Frame alignment FSM: next state.
  always_comb begin
    state_nxt = state;
    if (fm_end) state_nxt = RUN;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_FRAME;
      hs_q       <= '0;
      vs_q       <= '0;
      col        <= '0;
      row        <= '0;
      ptr        <= NR'(1);
      acc_d      <= 1'b0;
      emit_d     <= 1'b0;
      emit_q     <= 1'b0;
      ovf        <= 1'b0;
      len_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      hs_q       <= {hs_q[0], hsync};
      vs_q       <= {vs_q[0], vsync};
      col        <= acc ? col_eff + COL_W'(1) : col_eff;
      row        <= row_eff;
      ptr        <= ptr_eff;
      acc_d      <= acc;
      emit_d     <= acc & (row_eff == ROW_W'(WIN - 1)) & (col_eff >= COL_W'(WIN - 1));
      emit_q     <= acc_d & emit_d;
      frame_done <= fm_end;
      if (emit_q & fifo_full) ovf <= 1'b1;
      else if (ovf_clr)       ovf <= 1'b0;
      if (px_in & ~acc)       len_err <= 1'b1;
      else if (ovf_clr)       len_err <= 1'b0;
    end
  end

  // Line RAM ring; the oldest line is overwritten as it is read.
  for (genvar k = 0; k < int'(NR); k++) begin : g_ram
    win_line_buf_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_COLS),
      .AW     (AW)
    ) u_ram (
      .clk   (clk),
      .we    (acc & ptr_eff[k]),
      .waddr (col_eff[AW-1:0]),
      .wdata (pdata),
      .re    (acc),
      .raddr (col_eff[AW-1:0]),
      .rdata (rd_data[k])
    );
  end

  // Column vector: stored lines oldest to newest, then the live pixel.
  always_comb begin
    int idx;
    colvec = '0;
    for (int r = 0; r < int'(NR); r++) begin
      idx = int'(old_idx_d) + r;
      if (idx >= int'(NR)) idx = idx - int'(NR);
      colvec[r] = rd_data[IDX_W'(idx)];
    end
    colvec[WIN-1] = pix_d;
  end

  // Live pixel delay and window shift register.
  always_ff @(posedge clk) begin
    if (acc) begin
      pix_d     <= pdata;
      old_idx_d <= old_idx;
    end
    if (acc_d) begin
      for (int r = 0; r < int'(WIN); r++) begin
        for (int c = 0; c < int'(WIN) - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][WIN-1] <= colvec[r];
      end
    end
  end

  win_line_buf_fifo #(
    .DW    (WIN_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (emit_q),
    .wr_data (win),
    .full    (fifo_full),
    .vld     (axis_o_vld),
    .rdy     (axis_o_rdy),
    .rd_data (axis_o_data)
  );

endmodule
